// File: rtl/pipeline_stage_reg.sv
// Parametrised pipeline boundary register: valid/ready handshake with back-pressure,
// optional two-entry skid buffer (registered in_ready) and synchronous flush.
module pipeline_stage_reg #(
   parameter int unsigned WIDTH         = 32,
   parameter bit          SKID          = 1'b1,
   parameter bit          ZERO_ON_FLUSH = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   assign out_valid = (state != EMPTY);
   assign occupancy = state;
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   generate
      if (SKID) begin : g_skid_ready
         // Depends on registered state only, so no out_ready -> in_ready path.
         assign in_ready = (state != TWO);
      end else begin : g_pass_ready
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   always_comb begin
      // NOTE: every output of this block gets a default first; a missed branch
      // would otherwise infer a latch instead of a hold-through-the-register.
      state_nxt = state;
      main_d    = main_q;
      skid_d    = skid_q;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               main_d    = in_data;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire && SKID) begin
               skid_d    = in_data;
               state_nxt = TWO;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               main_d    = skid_q;
               state_nxt = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase

      // Flush wins over any transfer this cycle; an out_fire still completes downstream.
      if (flush) begin
         state_nxt = EMPTY;
         main_d    = ZERO_ON_FLUSH ? '0 : main_q;
         skid_d    = ZERO_ON_FLUSH ? '0 : skid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         // NOTE: payload registers are reset because out_data must read 0 after
         // reset; a plain datapath register would normally be left unreset.
         main_q <= '0;
         skid_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state  <= state_nxt;
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: SKID=1 and SKID=0 instances share one stimulus stream;
// each is scored against its own bounded-FIFO reference model.
module tb_pipeline_stage_reg;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         out_ready;

   logic         in_ready_s, out_valid_s;
   logic [W-1:0] out_data_s;
   logic [1:0]   occ_s;
   logic         in_ready_n, out_valid_n;
   logic [W-1:0] out_data_n;
   logic [1:0]   occ_n;

   int errors = 0;
   int checks = 0;

   // Reference model per instance: up to two queued payloads, oldest in slot 0.
   logic [W-1:0] mdl [2][2];
   int           cnt [2];
   bit           zero_known [2];

   always #5 clk = ~clk;

   pipeline_stage_reg #(.WIDTH(W), .SKID(1'b1), .ZERO_ON_FLUSH(1'b1)) dut_skid (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .occupancy(occ_s)
   );

   pipeline_stage_reg #(.WIDTH(W), .SKID(1'b0), .ZERO_ON_FLUSH(1'b1)) dut_pass (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
      .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
      .occupancy(occ_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare one instance against its model, then advance the model by one edge.
   task automatic model_step(input int k, input logic act_ready, input logic act_valid,
                             input logic [W-1:0] act_data, input logic [1:0] act_occ);
      bit exp_ready;
      exp_ready = (k == 0) ? (cnt[k] < 2) : (cnt[k] == 0 || out_ready);
      check($sformatf("in_ready[%0d]", k), {31'd0, act_ready}, {31'd0, exp_ready});
      check($sformatf("out_valid[%0d]", k), {31'd0, act_valid}, {31'd0, cnt[k] != 0});
      check($sformatf("occupancy[%0d]", k), {30'd0, act_occ}, cnt[k]);
      if (cnt[k] == 0 && zero_known[k])
         check($sformatf("idle_data[%0d]", k), {16'd0, act_data}, 32'd0);
      if (cnt[k] != 0 && out_ready) begin
         check($sformatf("out_data[%0d]", k), {16'd0, act_data}, {16'd0, mdl[k][0]});
         mdl[k][0] = mdl[k][1];
         cnt[k]--;
      end
      if (flush) begin
         cnt[k]        = 0;
         zero_known[k] = 1'b1;
      end else if (in_valid && exp_ready) begin
         mdl[k][cnt[k]] = in_data;
         cnt[k]++;
         zero_known[k]  = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            cnt[k]        = 0;
            zero_known[k] = 1'b1;
         end
      end else begin
         model_step(0, in_ready_s, out_valid_s, out_data_s, occ_s);
         model_step(1, in_ready_n, out_valid_n, out_data_n, occ_n);
      end
   end

   task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming at full throughput.
      cyc(1'b1, 16'h0011, 1'b1, 1'b0);
      cyc(1'b1, 16'h0022, 1'b1, 1'b0);
      cyc(1'b1, 16'h0033, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);

      // Stall and fill, then drain in order.
      cyc(1'b1, 16'h00A1, 1'b0, 1'b0);
      cyc(1'b1, 16'h00A2, 1'b0, 1'b0);
      cyc(1'b1, 16'h00A3, 1'b0, 1'b0);
      cyc(1'b1, 16'h00A3, 1'b0, 1'b0);
      cyc(1'b1, 16'h00A3, 1'b1, 1'b0);
      cyc(1'b1, 16'h00A3, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

      // Flush colliding with an out_fire while full.
      cyc(1'b1, 16'h00B1, 1'b0, 1'b0);
      cyc(1'b1, 16'h00B2, 1'b0, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);

      // Flush together with input while empty.
      cyc(1'b1, 16'h00C5, 1'b0, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);

      // Asynchronous reset mid-stream with the skid instance full.
      cyc(1'b1, 16'h00E1, 1'b0, 1'b0);
      cyc(1'b1, 16'h00E2, 1'b0, 1'b0);
      check("pre_reset_occupancy", {30'd0, occ_s}, 32'd2);
      #1 rst_n = 1'b0;
      #1;
      check("async_out_valid", {31'd0, out_valid_s}, 32'd0);
      check("async_occupancy", {30'd0, occ_s}, 32'd0);
      check("async_out_data", {16'd0, out_data_s}, 32'd0);
      check("async_in_ready", {31'd0, in_ready_s}, 32'd1);
      check("async_pass_valid", {31'd0, out_valid_n}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 16'h00D7, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

      // Randomised traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6,
             $urandom_range(0, 19) == 0);
      end
      repeat (3) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Generic, parametrised pipeline boundary register for the processor. It replaces hand-coded per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries any packed payload of `WIDTH` bits. It uses a valid/ready handshake with back-pressure, an optional two-entry skid buffer so `in_ready` is registered, and a synchronous flush for branch/trap squash. It is instantiated between adjacent stages, with the payload bound to that stage's packed struct.

## Interface
- `WIDTH`, default 32: payload width in bits; ≥1.
- `SKID`, default 1: 1 selects a two-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `ZERO_ON_FLUSH`, default 1: 1 clears the payload registers on flush; 0 leaves them unchanged (only valid is killed).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash; empties the stage at the next edge.
- `in_valid` in 1: upstream payload valid.
- `in_ready` out 1: stage can accept; a transfer (in_fire) occurs when `in_valid & in_ready`.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` holds a valid entry.
- `out_ready` in 1: downstream accepts; out_fire = `out_valid & out_ready`.
- `out_data` out WIDTH: payload of the oldest entry.
- `occupancy` out 2: number of held entries (0..2; maximum 1 when SKID=0).

## Operation
- Storage: `main` register (head, drives `out_data`) and, when SKID=1, a `skid` register. State is EMPTY, ONE, or TWO (TWO is unreachable when SKID=0).
- Outputs: `out_valid` = (state != EMPTY). `occupancy` = 0/1/2 for EMPTY/ONE/TWO.
- `in_ready`, SKID=1: `in_ready` = (state != TWO). It is a function of registered state only, with no combinational path from `out_ready`.
- `in_ready`, SKID=0: `in_ready` = !out_valid | out_ready (combinational pass-through).
- Transitions, no flush:
  - EMPTY: on in_fire, `main` ← `in_data`, go to ONE.
  - ONE, in_fire and out_fire: `main` ← `in_data`, stay in ONE.
  - ONE, in_fire without out_fire: `skid` ← `in_data`, go to TWO (SKID=1 only; cannot occur when SKID=0 because `in_ready` is 0).
  - ONE, out_fire without in_fire: go to EMPTY.
  - TWO, on out_fire: `main` ← `skid`, go to ONE. No input is accepted because `in_ready` is 0.
  - Otherwise: hold.
- Ordering: strict FIFO. The `skid` entry is always younger than `main`.
- Flush:
  - Highest priority. Next state is EMPTY regardless of in_fire or out_fire in the same cycle.
  - Upstream sees in_fire that cycle (ready was asserted), but the data is discarded.
  - Downstream may see out_fire that cycle; that transfer is valid from downstream's view. Flush only prevents retention.
  - If ZERO_ON_FLUSH=1, `main` and `skid` are cleared to 0.
- Payload contents are opaque. The block never inspects embedded valid or control fields.
- Registers hold their value when not written (no spurious toggling when idle).

## Timing
- Reset (async assert, sync release):
  - State EMPTY, `main` = 0, `skid` = 0.
  - `out_valid` = 0, `occupancy` = 0, `out_data` = 0.
  - `in_ready` = 1 for SKID=1. For SKID=0, `in_ready` = 1 while `out_valid` is 0.
- Latency: in_fire at edge N makes the data visible on `out_data` with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput: one transfer per cycle when `out_ready` is held at 1, in both modes.
- SKID=1 back-pressure: `in_ready` deasserts one edge after the stage becomes full. The skid entry absorbs the in-flight beat.
- Reset asserted mid-operation: all entries are lost immediately and asynchronously. Outputs take their reset values without waiting for `clk`.
- Handshake rules:
  - Upstream must hold `in_data` stable while `in_valid` is high and `in_ready` is low. This is not checked here.
  - The block guarantees `out_data` is stable while `out_valid` is high and `out_ready` is low.

## Test plan
- Streaming, SKID=1: send 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=1. Required: `out_data` shows 0x11, 0x22, 0x33 one cycle after each input; `occupancy` stays 1; `in_ready` never drops.
- Stall/fill, SKID=1: hold `out_ready`=0 and offer 0xA1, 0xA2, 0xA3. Required:
  - 0xA1 and 0xA2 are accepted; `in_ready`=0 after the second accept and `occupancy`=2.
  - 0xA3 is held upstream.
  - After releasing `out_ready`, the outputs are 0xA1, 0xA2, 0xA3 in order with no loss or duplication.
- Flush collision: with state TWO (0xB1, 0xB2), assert `flush` together with `out_ready`=1. Required:
  - 0xB1 is delivered that cycle.
  - Next cycle: `out_valid`=0, `occupancy`=0, `out_data`=0 (ZERO_ON_FLUSH=1), `in_ready`=1.
- Flush with simultaneous input in EMPTY: `in_valid`=1 with 0xC5 and `flush`=1. Required: the stage stays empty and 0xC5 never appears on `out_data`.
- Async reset mid-stream: assert `rst_n`=0 between clock edges while `occupancy`=2. Required: `out_valid`=0 and `occupancy`=0 immediately. After release, the next input 0xD7 emerges alone.
- SKID=0 mode: with `out_valid`=1 and `out_ready`=0, `in_ready`=0. When `out_ready` is raised in the same cycle as `in_valid`, `in_ready`=1 combinationally and the new beat replaces the head. `occupancy` never exceeds 1.
